pc_sequencer: RTL and testbench

// - Program-address sequencer for the MC14500B-style 1-bit control core.
// - Parametrised successor of the plain program counter:
//   - adds skip, subroutine call/return via an internal LIFO stack of depth STACK_DEPTH, and hold;
//   - flags stack overflow and underflow.
// - Sits between the instruction decoder (drives op/target) and program memory (consumes pc).

---
 rtl/mc14500_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/ret_stack.sv | 67 ++++++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500B-style control core.
// Contents:
//   pc_op_t        - sequencer operation issued by the instruction decoder
//   PC_ADDR_W      - default program address width
//   PC_STACK_DEPTH - default return-stack depth
package mc14500_pkg;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_SKIP = 3'd1,
    PC_JMP  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_HOLD = 3'd5
  } pc_op_t;

  localparam int unsigned PC_ADDR_W      = 12;
  localparam int unsigned PC_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder <-> sequencer bus.
// Signals:
//   en, op, target        - request from the decoder (master drives)
//   pc                    - current program address
//   stack_lvl             - occupied return-stack entries
//   stack_full/stack_empt - stack level flags
//   ovf_pulse/unf_pulse   - one-cycle CALL-while-full / RET-while-empty pulses
//   err_sticky            - latched error, cleared only by reset
interface pc_sequencer_if
  import mc14500_pkg::*;
#(
  parameter int unsigned ADDR_W      = PC_ADDR_W,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH,
  localparam int unsigned LVL_W      = $clog2(STACK_DEPTH + 1)
);

  logic              en;
  pc_op_t            op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic [LVL_W-1:0]  stack_lvl;
  logic              stack_full;
  logic              stack_empt;
  logic              ovf_pulse;
  logic              unf_pulse;
  logic              err_sticky;

  modport master (
    output en, op, target,
    input  pc, stack_lvl, stack_full, stack_empt, ovf_pulse, unf_pulse, err_sticky
  );

  modport slave (
    input  en, op, target,
    output pc, stack_lvl, stack_full, stack_empt, ovf_pulse, unf_pulse, err_sticky
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with registered storage.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (empties the stack)
//   i_push    - write i_din on top; ignored when full
//   i_pop     - discard top entry; ignored when empty
//   i_din     - address to push
//   o_dout    - current top of stack (entry 0 when empty)
//   o_lvl     - occupied entries
//   o_full    - o_lvl == DEPTH
//   o_empty   - o_lvl == 0
module ret_stack #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_din,
  output logic [ADDR_W-1:0] o_dout,
  output logic [LVL_W-1:0]  o_lvl,
  output logic              o_full,
  output logic              o_empty
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]  r_lvl;
  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_full    = (r_lvl == LVL_W'(DEPTH));
  assign w_empty   = (r_lvl == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;
  // Indices only matter when the guarded operation is legal, so truncation is safe.
  assign w_wr_idx  = IDX_W'(r_lvl);
  assign w_rd_idx  = w_empty ? '0 : IDX_W'(r_lvl - LVL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= '0;
    end else if (w_do_push) begin
      r_lvl <= r_lvl + LVL_W'(1);
    end else if (w_do_pop) begin
      r_lvl <= r_lvl - LVL_W'(1);
    end
  end

  // Contents are don't-care after reset; popped entries are left in place.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  assign o_dout  = r_mem[w_rd_idx];
  assign o_lvl   = r_lvl;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/pc_sequencer.sv
// Program-address sequencer: increment, skip, jump, call/return through a
// return-address stack, and hold, with overflow/underflow reporting.
// Ports:
//   clk  - single clock
//   rst  - synchronous active-high reset (pc <= RESET_VECTOR, stack emptied, errors cleared)
//   bus  - pc_sequencer_if slave: en/op/target in; pc, stack status, error flags out
module pc_sequencer
  import mc14500_pkg::*;
#(
  parameter int unsigned       ADDR_W       = PC_ADDR_W,
  parameter int unsigned       STACK_DEPTH  = PC_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  localparam int unsigned      LVL_W        = $clog2(STACK_DEPTH + 1)
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;
  logic              r_err;

  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_skip;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf;
  logic              w_unf;
  logic [ADDR_W-1:0] w_stk_top;
  logic [LVL_W-1:0]  w_stk_lvl;
  logic              w_stk_full;
  logic              w_stk_empty;

  // Widths wrap modulo 2**ADDR_W, including the pushed return address.
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_pc_skip = r_pc + ADDR_W'(2);

  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (bus.en) begin
      case (bus.op)
        PC_INC:  w_pc_next = w_pc_inc;
        PC_SKIP: w_pc_next = w_pc_skip;
        PC_JMP:  w_pc_next = bus.target;
        PC_CALL: begin
          if (w_stk_full) begin
            w_pc_next = w_pc_inc;
            w_ovf     = 1'b1;
          end else begin
            w_pc_next = bus.target;
            w_push    = 1'b1;
          end
        end
        PC_RET: begin
          if (w_stk_empty) begin
            w_pc_next = w_pc_inc;
            w_unf     = 1'b1;
          end else begin
            w_pc_next = w_stk_top;
            w_pop     = 1'b1;
          end
        end
        default: w_pc_next = r_pc;  // PC_HOLD and undefined encodings
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      r_err <= r_err | w_ovf | w_unf;
    end
  end

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_pc_inc),
    .o_dout  (w_stk_top),
    .o_lvl   (w_stk_lvl),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  assign bus.pc         = r_pc;
  assign bus.stack_lvl  = w_stk_lvl;
  assign bus.stack_full = w_stk_full;
  assign bus.stack_empt = w_stk_empty;
  assign bus.ovf_pulse  = r_ovf;
  assign bus.unf_pulse  = r_unf;
  assign bus.err_sticky = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=12, STACK_DEPTH=4, RESET_VECTOR=0x010).
module tb_pc_sequencer;
  import mc14500_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RV  = 12'h010;

  logic clk;
  logic rst;

  pc_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .ADDR_W       (AW),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter plus a queue used as the return stack.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack[$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_err;

  task automatic model_step(input bit r, input bit e, input pc_op_t o, input logic [AW-1:0] t);
    m_ovf = 0;
    m_unf = 0;
    if (r) begin
      m_pc = RV;
      m_stack.delete();
      m_err = 0;
    end else if (e) begin
      case (o)
        PC_INC:  m_pc = m_pc + 12'd1;
        PC_SKIP: m_pc = m_pc + 12'd2;
        PC_JMP:  m_pc = t;
        PC_CALL:
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back(m_pc + 12'd1);
            m_pc = t;
          end else begin
            m_pc = m_pc + 12'd1;
            m_ovf = 1;
            m_err = 1;
          end
        PC_RET:
          if (m_stack.size() > 0) begin
            m_pc = m_stack.pop_back();
          end else begin
            m_pc = m_pc + 12'd1;
            m_unf = 1;
            m_err = 1;
          end
        default: ;
      endcase
    end
  endtask

  // Apply one cycle of stimulus; returns #1 after the edge so outputs are settled.
  task automatic drive(input bit r, input bit e, input pc_op_t o, input logic [AW-1:0] t);
    rst        = r;
    bus.en     = e;
    bus.op     = o;
    bus.target = t;
    @(posedge clk);
    model_step(r, e, o, t);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, PC_INC, '0);
    checks++;
    if (bus.pc !== 12'h010 || bus.stack_lvl !== 3'd0 || bus.stack_empt !== 1'b1 ||
        bus.stack_full !== 1'b0 || bus.ovf_pulse !== 1'b0 || bus.unf_pulse !== 1'b0 ||
        bus.err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h lvl=%0d empt=%b full=%b ovf=%b unf=%b err=%b, want 010 0 1 0 0 0 0",
               bus.pc, bus.stack_lvl, bus.stack_empt, bus.stack_full, bus.ovf_pulse,
               bus.unf_pulse, bus.err_sticky);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, PC_INC, '0);
      checks++;
      if (bus.pc !== 12'(12'h010 + i)) begin
        errors++;
        $display("FAIL inc_%0d pc=%h want %h", i, bus.pc, 12'(12'h010 + i));
      end
    end
    drive(0, 1, PC_CALL, 12'h123);
    drive(1, 1, PC_INC, '0);
    checks++;
    if (bus.pc !== 12'h010 || bus.stack_lvl !== 3'd0) begin
      errors++;
      $display("FAIL reset_midrun pc=%h lvl=%0d want 010 0", bus.pc, bus.stack_lvl);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, PC_JMP, 12'hFFE);
    drive(0, 1, PC_INC, '0);
    checks++;
    if (bus.pc !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_inc pc=%h want fff", bus.pc);
    end
    drive(0, 1, PC_SKIP, '0);
    checks++;
    if (bus.pc !== 12'h001) begin
      errors++;
      $display("FAIL wrap_skip pc=%h want 001", bus.pc);
    end
    drive(0, 1, PC_CALL, 12'h222);
    drive(0, 1, PC_JMP, 12'h7A5);
    checks++;
    if (bus.pc !== 12'h7A5 || bus.stack_lvl !== 3'd1) begin
      errors++;
      $display("FAIL jmp pc=%h lvl=%0d want 7a5 1", bus.pc, bus.stack_lvl);
    end
  endtask

  task automatic test_call_ret();
    logic [AW-1:0] exp_pc [4];
    logic [2:0]    exp_lvl[4];
    pc_op_t        ops    [4];
    logic [AW-1:0] tgts   [4];
    exp_pc  = '{12'h200, 12'h300, 12'h201, 12'h101};
    exp_lvl = '{3'd1, 3'd2, 3'd1, 3'd0};
    ops     = '{PC_CALL, PC_CALL, PC_RET, PC_RET};
    tgts    = '{12'h200, 12'h300, 12'h000, 12'h000};
    drive(1, 0, PC_HOLD, '0);
    drive(0, 1, PC_JMP, 12'h100);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, ops[i], tgts[i]);
      checks++;
      if (bus.pc !== exp_pc[i] || bus.stack_lvl !== exp_lvl[i]) begin
        errors++;
        $display("FAIL call_ret_%0d pc=%h lvl=%0d want %h %0d", i, bus.pc, bus.stack_lvl,
                 exp_pc[i], exp_lvl[i]);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, PC_HOLD, '0);
    drive(0, 1, PC_JMP, 12'h020);
    for (int i = 0; i < 5; i++) drive(0, 1, PC_CALL, 12'(12'h400 + 16 * i));
    checks++;
    if (bus.pc !== 12'h431 || bus.stack_lvl !== 3'd4 || bus.stack_full !== 1'b1 ||
        bus.ovf_pulse !== 1'b1 || bus.err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL overflow pc=%h lvl=%0d full=%b ovf=%b err=%b want 431 4 1 1 1",
               bus.pc, bus.stack_lvl, bus.stack_full, bus.ovf_pulse, bus.err_sticky);
    end
    drive(0, 1, PC_HOLD, '0);
    checks++;
    if (bus.ovf_pulse !== 1'b0 || bus.pc !== 12'h431 || bus.err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_one_cycle ovf=%b pc=%h err=%b want 0 431 1",
               bus.ovf_pulse, bus.pc, bus.err_sticky);
    end
    // Full stack: RET then CALL back to back.
    drive(0, 1, PC_RET, '0);
    checks++;
    if (bus.pc !== 12'h421 || bus.stack_lvl !== 3'd3) begin
      errors++;
      $display("FAIL ret_from_full pc=%h lvl=%0d want 421 3", bus.pc, bus.stack_lvl);
    end
    drive(0, 1, PC_CALL, 12'h555);
    checks++;
    if (bus.pc !== 12'h555 || bus.stack_lvl !== 3'd4 || bus.ovf_pulse !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_call pc=%h lvl=%0d ovf=%b want 555 4 0",
               bus.pc, bus.stack_lvl, bus.ovf_pulse);
    end
    drive(0, 1, PC_RET, '0);
    checks++;
    if (bus.pc !== 12'h422) begin
      errors++;
      $display("FAIL back_to_back_ret pc=%h want 422", bus.pc);
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, PC_HOLD, '0);
    drive(0, 1, PC_JMP, 12'h050);
    drive(0, 1, PC_RET, '0);
    checks++;
    if (bus.pc !== 12'h051 || bus.unf_pulse !== 1'b1 || bus.err_sticky !== 1'b1 ||
        bus.stack_lvl !== 3'd0) begin
      errors++;
      $display("FAIL underflow pc=%h unf=%b err=%b lvl=%0d want 051 1 1 0",
               bus.pc, bus.unf_pulse, bus.err_sticky, bus.stack_lvl);
    end
    drive(0, 1, PC_INC, '0);
    drive(0, 1, PC_INC, '0);
    checks++;
    if (bus.unf_pulse !== 1'b0 || bus.err_sticky !== 1'b1 || bus.pc !== 12'h053) begin
      errors++;
      $display("FAIL err_sticky_hold unf=%b err=%b pc=%h want 0 1 053",
               bus.unf_pulse, bus.err_sticky, bus.pc);
    end
    drive(1, 0, PC_HOLD, '0);
    checks++;
    if (bus.err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared err=%b want 0", bus.err_sticky);
    end
  endtask

  task automatic test_wrap_call_en();
    drive(1, 0, PC_HOLD, '0);
    drive(0, 1, PC_JMP, 12'hFFF);
    drive(0, 1, PC_CALL, 12'h080);
    checks++;
    if (bus.pc !== 12'h080 || bus.stack_lvl !== 3'd1) begin
      errors++;
      $display("FAIL wrap_call pc=%h lvl=%0d want 080 1", bus.pc, bus.stack_lvl);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, (i == 1) ? PC_RET : PC_INC, 12'h3C3);
      checks++;
      if (bus.pc !== 12'h080 || bus.ovf_pulse !== 1'b0 || bus.unf_pulse !== 1'b0 ||
          bus.stack_lvl !== 3'd1) begin
        errors++;
        $display("FAIL en_low_%0d pc=%h ovf=%b unf=%b lvl=%0d want 080 0 0 1", i, bus.pc,
                 bus.ovf_pulse, bus.unf_pulse, bus.stack_lvl);
      end
    end
    drive(0, 1, PC_RET, '0);
    checks++;
    if (bus.pc !== 12'h000 || bus.stack_lvl !== 3'd0) begin
      errors++;
      $display("FAIL wrap_ret pc=%h lvl=%0d want 000 0", bus.pc, bus.stack_lvl);
    end
  endtask

  task automatic test_random();
    int     n_err;
    bit     r;
    bit     e;
    pc_op_t o;
    n_err = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 4) != 0);
      o = pc_op_t'($urandom_range(0, 7));
      drive(r, e, o, 12'($urandom));
      checks++;
      if (bus.pc !== m_pc || int'(bus.stack_lvl) != m_stack.size() ||
          bus.stack_full !== (m_stack.size() == DEPTH) ||
          bus.stack_empt !== (m_stack.size() == 0) ||
          bus.ovf_pulse !== m_ovf || bus.unf_pulse !== m_unf || bus.err_sticky !== m_err) begin
        errors++;
        n_err++;
        if (n_err <= 10)
          $display("FAIL random_%0d pc=%h lvl=%0d full=%b empt=%b ovf=%b unf=%b err=%b want %h %0d %b %b %b %b %b",
                   i, bus.pc, bus.stack_lvl, bus.stack_full, bus.stack_empt, bus.ovf_pulse,
                   bus.unf_pulse, bus.err_sticky, m_pc, m_stack.size(),
                   m_stack.size() == DEPTH, m_stack.size() == 0, m_ovf, m_unf, m_err);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.op     = PC_HOLD;
    bus.target = '0;
    m_pc       = RV;
    m_ovf      = 0;
    m_unf      = 0;
    m_err      = 0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap_call_en();
    drive(1, 0, PC_HOLD, '0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
